// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the hazard sequencer: stage bit positions, FSM states
// and the per-row stall/flush masks of the priority encoder.
package pipeline_hazard_ctrl_pkg;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EXE = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_MC_WAIT = 2'd1,
        HZ_MC_HOLD = 2'd2
    } hz_state_e;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] FLUSH_NONE = 6'b000000;
    localparam logic [5:0] FLUSH_ALL  = 6'b111111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] FLUSH_MEM  = 6'b100000;
    localparam logic [5:0] STALL_MC   = 6'b001111;
    localparam logic [5:0] FLUSH_MC   = 6'b010000;
    localparam logic [5:0] FLUSH_BR   = 6'b000110;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] FLUSH_LU   = 6'b001000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] FLUSH_IF   = 6'b000100;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detection and the priority encoder that turns the
// active hazard sources into per-stage stall/flush masks.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   rst,
    input  logic [RADDR_WIDTH-1:0] id_reg1_raddr_i,
    input  logic [RADDR_WIDTH-1:0] id_reg2_raddr_i,
    input  logic                   id_reg1_re_i,
    input  logic                   id_reg2_re_i,
    input  logic [RADDR_WIDTH-1:0] exe_reg_waddr_i,
    input  logic                   exe_reg_we_i,
    input  logic                   exe_is_load_i,
    input  logic                   mem_stall_i,
    input  logic                   mc_busy_i,
    input  logic                   exe_branch_i,
    input  logic                   imem_ready_i,
    output logic [5:0]             stall_o,
    output logic [5:0]             flush_o,
    output logic                   redirect_o
);

    logic load_use;

    always_comb begin
        load_use = exe_is_load_i & exe_reg_we_i & (exe_reg_waddr_i != '0) &
                   ((id_reg1_re_i & (id_reg1_raddr_i == exe_reg_waddr_i)) |
                    (id_reg2_re_i & (id_reg2_raddr_i == exe_reg_waddr_i)));

        stall_o    = STALL_NONE;
        flush_o    = FLUSH_NONE;
        redirect_o = 1'b0;

        // A branch held under a memory or multi-cycle stall redirects only once it is released.
        if (rst) begin
            flush_o = FLUSH_ALL;
        end else if (mem_stall_i) begin
            stall_o = STALL_MEM;
            flush_o = FLUSH_MEM;
        end else if (mc_busy_i) begin
            stall_o = STALL_MC;
            flush_o = FLUSH_MC;
        end else if (exe_branch_i) begin
            flush_o    = FLUSH_BR;
            redirect_o = 1'b1;
        end else if (load_use) begin
            stall_o = STALL_LU;
            flush_o = FLUSH_LU;
        end else if (!imem_ready_i) begin
            stall_o = STALL_IF;
            flush_o = FLUSH_IF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: multi-cycle FSM with watchdog,
// stall performance counter, and the hazard priority encoder.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RADDR_WIDTH = 5,
    parameter int PC_WIDTH    = 32,
    parameter int MC_MAX_CYC  = 40,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RADDR_WIDTH-1:0] id_reg1_raddr_i,
    input  logic [RADDR_WIDTH-1:0] id_reg2_raddr_i,
    input  logic                   id_reg1_re_i,
    input  logic                   id_reg2_re_i,
    input  logic [RADDR_WIDTH-1:0] exe_reg_waddr_i,
    input  logic                   exe_reg_we_i,
    input  logic                   exe_is_load_i,
    input  logic                   exe_mc_op_i,
    input  logic                   mc_done_i,
    input  logic                   exe_branch_i,
    input  logic [PC_WIDTH-1:0]    exe_branch_target_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ack_i,
    input  logic                   imem_ready_i,
    output logic [5:0]             stall_o,
    output logic [5:0]             flush_o,
    output logic                   redirect_o,
    output logic [PC_WIDTH-1:0]    redirect_pc_o,
    output logic                   mc_start_o,
    output logic                   mc_timeout_o,
    output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

    localparam int WD_WIDTH = (MC_MAX_CYC > 1) ? $clog2(MC_MAX_CYC) : 1;

    hz_state_e            state_q, state_d;
    logic [WD_WIDTH-1:0]  wd_cnt_q, wd_cnt_d;
    logic                 mc_timeout_q, mc_timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 mem_stall;
    logic                 wd_expire;
    logic                 mc_busy;

    // MC_HOLD needs no term of its own in mc_busy: while memory still stalls the
    // memory row already holds EXE, and once it clears the op must leave EXE.
    always_comb begin
        mem_stall  = mem_req_i & ~mem_ack_i;
        wd_expire  = (state_q == HZ_MC_WAIT) & ~mc_done_i &
                     (wd_cnt_q == WD_WIDTH'(MC_MAX_CYC - 1));
        mc_busy    = ((state_q == HZ_MC_WAIT) & ~mc_done_i & ~wd_expire) |
                     ((state_q == HZ_RUN) & exe_mc_op_i);
        mc_start_o = ~rst & (state_q == HZ_RUN) & exe_mc_op_i & ~mem_stall;

        state_d = state_q;
        case (state_q)
            HZ_RUN: begin
                if (exe_mc_op_i && !mem_stall) state_d = HZ_MC_WAIT;
            end
            HZ_MC_WAIT: begin
                if (mc_done_i)      state_d = mem_stall ? HZ_MC_HOLD : HZ_RUN;
                else if (wd_expire) state_d = HZ_RUN;
            end
            HZ_MC_HOLD: begin
                if (!mem_stall) state_d = HZ_RUN;
            end
            default: state_d = HZ_RUN;
        endcase

        wd_cnt_d     = ((state_q == HZ_MC_WAIT) && (state_d == HZ_MC_WAIT)) ?
                       wd_cnt_q + 1'b1 : '0;
        mc_timeout_d = mc_timeout_q | wd_expire;
        stall_cnt_d  = stall_cnt_q + CNT_WIDTH'(stall_o[STG_PC]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HZ_RUN;
            wd_cnt_q     <= '0;
            mc_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wd_cnt_q     <= wd_cnt_d;
            mc_timeout_q <= mc_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    pipeline_hazard_ctrl_hazard_detect #(
        .RADDR_WIDTH (RADDR_WIDTH)
    ) u_hazard_detect (
        .rst             (rst),
        .id_reg1_raddr_i (id_reg1_raddr_i),
        .id_reg2_raddr_i (id_reg2_raddr_i),
        .id_reg1_re_i    (id_reg1_re_i),
        .id_reg2_re_i    (id_reg2_re_i),
        .exe_reg_waddr_i (exe_reg_waddr_i),
        .exe_reg_we_i    (exe_reg_we_i),
        .exe_is_load_i   (exe_is_load_i),
        .mem_stall_i     (mem_stall),
        .mc_busy_i       (mc_busy),
        .exe_branch_i    (exe_branch_i),
        .imem_ready_i    (imem_ready_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o)
    );

    assign redirect_pc_o = exe_branch_target_i;
    assign mc_timeout_o  = mc_timeout_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl: load-use, multi-cycle,
// memory wait, branch redirect, MC_HOLD, watchdog and reset behaviour.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_reg1_raddr_i, id_reg2_raddr_i, exe_reg_waddr_i;
    logic        id_reg1_re_i, id_reg2_re_i, exe_reg_we_i, exe_is_load_i;
    logic        exe_mc_op_i, mc_done_i, exe_branch_i;
    logic [31:0] exe_branch_target_i;
    logic        mem_req_i, mem_ack_i, imem_ready_i;
    logic [5:0]  stall_o, flush_o;
    logic        redirect_o, mc_start_o, mc_timeout_o;
    logic [31:0] redirect_pc_o, stall_cnt_o;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_cnt      = '0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_reg1_raddr_i     (id_reg1_raddr_i),
        .id_reg2_raddr_i     (id_reg2_raddr_i),
        .id_reg1_re_i        (id_reg1_re_i),
        .id_reg2_re_i        (id_reg2_re_i),
        .exe_reg_waddr_i     (exe_reg_waddr_i),
        .exe_reg_we_i        (exe_reg_we_i),
        .exe_is_load_i       (exe_is_load_i),
        .exe_mc_op_i         (exe_mc_op_i),
        .mc_done_i           (mc_done_i),
        .exe_branch_i        (exe_branch_i),
        .exe_branch_target_i (exe_branch_target_i),
        .mem_req_i           (mem_req_i),
        .mem_ack_i           (mem_ack_i),
        .imem_ready_i        (imem_ready_i),
        .stall_o             (stall_o),
        .flush_o             (flush_o),
        .redirect_o          (redirect_o),
        .redirect_pc_o       (redirect_pc_o),
        .mc_start_o          (mc_start_o),
        .mc_timeout_o        (mc_timeout_o),
        .stall_cnt_o         (stall_cnt_o)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_masks(input string tag, input logic [5:0] exp_stall,
                               input logic [5:0] exp_flush, input logic exp_redirect,
                               input logic exp_start);
        check_output({tag, ".stall"}, 32'(stall_o), 32'(exp_stall));
        check_output({tag, ".flush"}, 32'(flush_o), 32'(exp_flush));
        check_output({tag, ".redirect"}, 32'(redirect_o), 32'(exp_redirect));
        check_output({tag, ".mc_start"}, 32'(mc_start_o), 32'(exp_start));
        exp_cnt = exp_cnt + 32'(exp_stall[0]);
    endtask

    task automatic apply_stimulus_idle();
        id_reg1_raddr_i     = '0;
        id_reg2_raddr_i     = '0;
        id_reg1_re_i        = 1'b0;
        id_reg2_re_i        = 1'b0;
        exe_reg_waddr_i     = '0;
        exe_reg_we_i        = 1'b0;
        exe_is_load_i       = 1'b0;
        exe_mc_op_i         = 1'b0;
        mc_done_i           = 1'b0;
        exe_branch_i        = 1'b0;
        exe_branch_target_i = '0;
        mem_req_i           = 1'b0;
        mem_ack_i           = 1'b0;
        imem_ready_i        = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus_idle();

        // Reset: combinational masks, then registered state after the reset edge.
        @(negedge clk); #1;
        check_masks("rst", 6'h00, 6'h3F, 1'b0, 1'b0);
        @(negedge clk); #1;
        check_output("rst.timeout", 32'(mc_timeout_o), 32'h0);
        check_output("rst.stall_cnt", stall_cnt_o, 32'h0);
        exp_cnt = '0;
        rst = 1'b0;

        @(negedge clk); #1;
        check_masks("idle", 6'h00, 6'h00, 1'b0, 1'b0);

        // Load-use hazards.
        @(negedge clk);
        exe_is_load_i = 1'b1; exe_reg_we_i = 1'b1; exe_reg_waddr_i = 5'd5;
        id_reg1_raddr_i = 5'd5; id_reg1_re_i = 1'b1;
        #1 check_masks("lu_rs1", 6'h07, 6'h08, 1'b0, 1'b0);
        @(negedge clk);
        exe_reg_waddr_i = 5'd0; id_reg1_raddr_i = 5'd0;
        #1 check_masks("lu_x0", 6'h00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        exe_reg_waddr_i = 5'd7; id_reg1_raddr_i = 5'd3;
        id_reg2_raddr_i = 5'd7; id_reg2_re_i = 1'b1;
        #1 check_masks("lu_rs2", 6'h07, 6'h08, 1'b0, 1'b0);
        @(negedge clk);
        id_reg2_re_i = 1'b0;
        #1 check_masks("lu_rs2_noread", 6'h00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        id_reg2_re_i = 1'b1; exe_is_load_i = 1'b0;
        #1 check_masks("lu_not_load", 6'h00, 6'h00, 1'b0, 1'b0);

        // Instruction fetch wait.
        @(negedge clk);
        apply_stimulus_idle(); imem_ready_i = 1'b0;
        #1 check_masks("if_wait", 6'h03, 6'h04, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus_idle();
        #1 check_output("cnt_after_lu", stall_cnt_o, 32'd3);
        check_masks("idle2", 6'h00, 6'h00, 1'b0, 1'b0);

        // Divide: start pulse, 33 wait cycles, done in cycle 34.
        @(negedge clk);
        exe_mc_op_i = 1'b1;
        #1 check_masks("div_start", 6'h0F, 6'h10, 1'b0, 1'b1);
        for (int i = 1; i < 34; i++) begin
            @(negedge clk); #1;
            check_masks("div_wait", 6'h0F, 6'h10, 1'b0, 1'b0);
        end
        @(negedge clk);
        mc_done_i = 1'b1;
        #1 check_masks("div_done", 6'h00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus_idle();
        #1 check_masks("div_after", 6'h00, 6'h00, 1'b0, 1'b0);
        check_output("cnt_after_div", stall_cnt_o, exp_cnt);

        // Data memory wait of three cycles, then ack.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_req_i = 1'b1; mem_ack_i = 1'b0;
            #1 check_masks("mem_wait", 6'h1F, 6'h20, 1'b0, 1'b0);
        end
        @(negedge clk);
        mem_ack_i = 1'b1;
        #1 check_masks("mem_ack", 6'h00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        mem_ack_i = 1'b0; imem_ready_i = 1'b0;
        #1 check_masks("mem_over_if", 6'h1F, 6'h20, 1'b0, 1'b0);

        // Branch held under a two-cycle memory stall, redirect exactly once.
        @(negedge clk);
        apply_stimulus_idle();
        exe_branch_i = 1'b1; exe_branch_target_i = 32'h0000_1234;
        mem_req_i = 1'b1;
        #1 check_masks("br_mem1", 6'h1F, 6'h20, 1'b0, 1'b0);
        @(negedge clk); #1;
        check_masks("br_mem2", 6'h1F, 6'h20, 1'b0, 1'b0);
        @(negedge clk);
        mem_ack_i = 1'b1;
        #1 check_masks("br_release", 6'h00, 6'h06, 1'b1, 1'b0);
        check_output("br_pc", redirect_pc_o, 32'h0000_1234);
        @(negedge clk);
        apply_stimulus_idle();
        #1 check_masks("br_after", 6'h00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        exe_branch_i = 1'b1; exe_is_load_i = 1'b1; exe_reg_we_i = 1'b1;
        exe_reg_waddr_i = 5'd9; id_reg1_raddr_i = 5'd9; id_reg1_re_i = 1'b1;
        imem_ready_i = 1'b0;
        #1 check_masks("br_over_lu", 6'h00, 6'h06, 1'b1, 1'b0);

        // MC_HOLD: done arrives during a memory stall.
        @(negedge clk);
        apply_stimulus_idle(); exe_mc_op_i = 1'b1;
        #1 check_masks("hold_start", 6'h0F, 6'h10, 1'b0, 1'b1);
        @(negedge clk); #1;
        check_masks("hold_wait", 6'h0F, 6'h10, 1'b0, 1'b0);
        @(negedge clk);
        mc_done_i = 1'b1; mem_req_i = 1'b1;
        #1 check_masks("hold_done", 6'h1F, 6'h20, 1'b0, 1'b0);
        @(negedge clk);
        mc_done_i = 1'b0;
        #1 check_masks("hold_mem", 6'h1F, 6'h20, 1'b0, 1'b0);
        @(negedge clk);
        mem_ack_i = 1'b1;
        #1 check_masks("hold_release", 6'h00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus_idle();
        #1 check_masks("hold_after", 6'h00, 6'h00, 1'b0, 1'b0);
        check_output("cnt_after_hold", stall_cnt_o, exp_cnt);

        // Watchdog: 40 cycles in MC_WAIT without done.
        @(negedge clk);
        exe_mc_op_i = 1'b1;
        #1 check_masks("wd_start", 6'h0F, 6'h10, 1'b0, 1'b1);
        for (int i = 1; i < 40; i++) begin
            @(negedge clk); #1;
            check_masks("wd_wait", 6'h0F, 6'h10, 1'b0, 1'b0);
        end
        @(negedge clk); #1;
        check_masks("wd_expire", 6'h00, 6'h00, 1'b0, 1'b0);
        check_output("wd_timeout_pre", 32'(mc_timeout_o), 32'h0);
        @(negedge clk);
        apply_stimulus_idle();
        #1 check_masks("wd_after", 6'h00, 6'h00, 1'b0, 1'b0);
        check_output("wd_timeout", 32'(mc_timeout_o), 32'h1);
        @(negedge clk); #1;
        check_output("wd_sticky", 32'(mc_timeout_o), 32'h1);
        check_output("cnt_after_wd", stall_cnt_o, exp_cnt);

        // Reset in the middle of a multi-cycle op.
        @(negedge clk);
        exe_mc_op_i = 1'b1;
        #1 check_masks("rst_mc_start", 6'h0F, 6'h10, 1'b0, 1'b1);
        @(negedge clk); #1;
        check_masks("rst_mc_wait", 6'h0F, 6'h10, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 check_masks("rst_mid", 6'h00, 6'h3F, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; apply_stimulus_idle();
        exp_cnt = '0;
        #1 check_output("rst2.timeout", 32'(mc_timeout_o), 32'h0);
        check_output("rst2.stall_cnt", stall_cnt_o, 32'h0);
        check_masks("rst2_run", 6'h00, 6'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
